// File: rtl/keypad_entry_ctrl_pkg.sv
// Shared definitions for the keypad entry controller: key codes, state encoding
// and result-width helper.
package keypad_entry_ctrl_pkg;

    localparam logic [3:0] KEY_ENTER  = 4'hA;
    localparam logic [3:0] KEY_BACK   = 4'hB;
    localparam logic [3:0] KEY_CANCEL = 4'hC;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_ENTRY   = 4'b0010,
        ST_CONVERT = 4'b0100,
        ST_PRESENT = 4'b1000
    } state_e;

    // Bits needed to hold any value of max_digits decimal digits.
    function automatic int min_val_w(input int max_digits);
        int p;
        p = 1;
        for (int i = 0; i < max_digits; i++) p = p * 10;
        return $clog2(p);
    endfunction

endpackage

// File: rtl/keypad_entry_ctrl_bcd_to_bin_seq.sv
// Iterative BCD-to-binary converter: one acc = acc*10 + digit step per cycle,
// most significant nibble first.
module bcd_to_bin_seq #(
    parameter int MAX_DIGITS = 4,
    parameter int VAL_W      = 14
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [4*MAX_DIGITS-1:0] bcd_i,
    output logic                    done_o,
    output logic [VAL_W-1:0]        value_o
);

    localparam int IW = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;

    logic             run_q;
    logic [IW-1:0]    idx_q;
    logic [VAL_W-1:0] acc_q;
    logic [3:0]       nib;
    logic [VAL_W-1:0] acc_d;

    // bcd_i must stay stable while running; the controller freezes its entry.
    assign nib   = bcd_i[{idx_q, 2'b00} +: 4];
    assign acc_d = acc_q * VAL_W'(10) + VAL_W'(nib);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            idx_q <= '0;
            acc_q <= '0;
        end else if (start_i) begin
            run_q <= 1'b1;
            idx_q <= IW'(MAX_DIGITS - 1);
            acc_q <= '0;
        end else if (run_q) begin
            acc_q <= acc_d;
            if (idx_q == '0) run_q <= 1'b0;
            else             idx_q <= idx_q - IW'(1);
        end
    end

    // High during the final step, so value_o holds the result the next cycle.
    assign done_o  = run_q && (idx_q == '0);
    assign value_o = acc_q;

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: collects decimal digits, handles edit keys and
// inactivity timeout, converts on enter and hands the value to the core.
//
// state      | meaning
// -----------+-------------------------------------------------
// ST_IDLE    | no digits held
// ST_ENTRY   | 1..MAX_DIGITS digits held, timeout running
// ST_CONVERT | BCD entry being converted to binary
// ST_PRESENT | cmd_vld_o high, waiting for cmd_rdy_i
module keypad_entry_ctrl
    import keypad_entry_ctrl_pkg::*;
#(
    parameter int MAX_DIGITS  = 4,
    parameter int VAL_W       = min_val_w(MAX_DIGITS),
    parameter int TIMEOUT_CYC = 500_000_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    key_vld_i,
    input  logic [3:0]              key_code_i,
    input  logic                    cmd_rdy_i,
    output logic                    cmd_vld_o,
    output logic [VAL_W-1:0]        cmd_value_o,
    output logic                    cmd_cancel_o,
    output logic                    timeout_pulse_o,
    output logic                    key_err_o,
    output logic [4*MAX_DIGITS-1:0] disp_bcd_o,
    output logic [2:0]              disp_cnt_o,
    output logic                    busy_o
);

    localparam int              DW       = 4 * MAX_DIGITS;
    localparam int              TMR_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [2:0]      MAX_CNT  = 3'(MAX_DIGITS);

    state_e           state_q;
    logic [DW-1:0]    disp_q;
    logic [2:0]       cnt_q;
    logic             cancel_q;
    logic             tmo_q;
    logic             err_q;
    logic [TMR_W-1:0] tmr_q;

    logic             editing;
    logic             conv_start;
    logic             conv_done;
    logic [DW-1:0]    disp_shl;

    assign editing    = (state_q == ST_IDLE) || (state_q == ST_ENTRY);
    assign conv_start = editing && key_vld_i && (key_code_i == KEY_ENTER) && (cnt_q != 3'd0);
    assign disp_shl   = (disp_q << 4) | DW'(key_code_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            disp_q   <= '0;
            cnt_q    <= 3'd0;
            cancel_q <= 1'b0;
            tmo_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cancel_q <= 1'b0;
            tmo_q    <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                ST_IDLE, ST_ENTRY: begin
                    if (key_vld_i) begin
                        if (key_code_i <= 4'd9) begin
                            if (cnt_q < MAX_CNT) begin
                                disp_q  <= disp_shl;
                                cnt_q   <= cnt_q + 3'd1;
                                state_q <= ST_ENTRY;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end else begin
                            case (key_code_i)
                                KEY_ENTER: begin
                                    if (cnt_q == 3'd0) err_q   <= 1'b1;
                                    else               state_q <= ST_CONVERT;
                                end
                                KEY_BACK: begin
                                    if (cnt_q == 3'd0) begin
                                        err_q <= 1'b1;
                                    end else begin
                                        disp_q  <= disp_q >> 4;
                                        cnt_q   <= cnt_q - 3'd1;
                                        state_q <= (cnt_q == 3'd1) ? ST_IDLE : ST_ENTRY;
                                    end
                                end
                                KEY_CANCEL: begin
                                    disp_q   <= '0;
                                    cnt_q    <= 3'd0;
                                    cancel_q <= 1'b1;
                                    state_q  <= ST_IDLE;
                                end
                                default: err_q <= 1'b1;
                            endcase
                        end
                    end else if ((state_q == ST_ENTRY) && (tmr_q == '0)) begin
                        disp_q  <= '0;
                        cnt_q   <= 3'd0;
                        tmo_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                ST_CONVERT: begin
                    if (conv_done) state_q <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (cmd_rdy_i) begin
                        disp_q  <= '0;
                        cnt_q   <= 3'd0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Down-counter reloaded by any key or outside ENTRY; zero is terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q <= TMR_LOAD;
        end else if ((state_q != ST_ENTRY) || key_vld_i) begin
            tmr_q <= TMR_LOAD;
        end else if (tmr_q != '0) begin
            tmr_q <= tmr_q - TMR_W'(1);
        end
    end

    bcd_to_bin_seq #(
        .MAX_DIGITS (MAX_DIGITS),
        .VAL_W      (VAL_W)
    ) u_conv (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (conv_start),
        .bcd_i   (disp_q),
        .done_o  (conv_done),
        .value_o (cmd_value_o)
    );

    assign cmd_vld_o       = (state_q == ST_PRESENT);
    assign busy_o          = (state_q == ST_CONVERT) || (state_q == ST_PRESENT);
    assign cmd_cancel_o    = cancel_q;
    assign timeout_pulse_o = tmo_q;
    assign key_err_o       = err_q;
    assign disp_bcd_o      = disp_q;
    assign disp_cnt_o      = cnt_q;

endmodule

// File: doc/keypad_entry_ctrl.md
Name: keypad_entry_ctrl

Overview:
Sequencing controller between the 4x4 keypad scanner and the vending-machine core. It turns single-cycle key events into a multi-digit decimal entry and handles digit, backspace, cancel and enter keys plus an inactivity timeout. On enter, it converts the BCD entry to binary over several cycles. It then presents the result to the core through a valid/ready handshake, while driving a BCD display image for the seven-segment driver.

Parameters:
MAX_DIGITS, 4, maximum digits held (1..7)
VAL_W, 14, width of cmd_value; must be >= ceil(log2(10^MAX_DIGITS))
TIMEOUT_CYC, 500_000_000, idle cycles in ENTRY before auto-clear (5 s at 100 MHz)

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  reset, asynchronous, active-low
key_vld  in  1  one-cycle strobe, key released and debounced
key_code  in  4  key value, sampled only when key_vld=1
cmd_rdy  in  1  core accepts cmd_value
cmd_vld  out  1  entry result valid
cmd_value  out  VAL_W  binary value of the entry
cmd_cancel  out  1  one-cycle pulse on cancel key
timeout_pulse  out  1  one-cycle pulse when an entry expires
key_err  out  1  one-cycle pulse when a key is rejected
disp_bcd  out  4*MAX_DIGITS  entry digits; nibble 0 = most recent digit
disp_cnt  out  3  number of digits held
busy  out  1  high in CONVERT and PRESENT

Behaviour:
- Reset is asynchronous. All outputs go to 0 and state goes to IDLE. cmd_vld drops immediately on reset, including mid-handshake.
- Key codes: 0-9 are digits; A = enter; B = backspace; C = cancel; D/E/F are invalid.
- A key event takes effect on the clock edge where key_vld=1. Outputs update the following cycle.
- States: IDLE (cnt=0), ENTRY (cnt>0), CONVERT, PRESENT.
- Digit key in IDLE or ENTRY:
  - cnt<MAX_DIGITS: disp_bcd shifts left one nibble, the digit is inserted at nibble 0, cnt increments, state -> ENTRY. Leading zeros count as digits.
  - cnt=MAX_DIGITS: key is dropped and key_err pulses.
- B (backspace):
  - cnt>0: disp_bcd shifts right one nibble with zero fill, cnt decrements. State -> IDLE when cnt reaches 0.
  - cnt=0: key_err pulses.
- C (cancel), in IDLE or ENTRY: disp_bcd and cnt clear, cmd_cancel pulses, state -> IDLE. The pulse is issued even if the entry is already empty, so the core can abort a pending purchase.
- A (enter):
  - cnt=0: key_err pulses, no state change.
  - cnt>0: state -> CONVERT.
- D/E/F in IDLE or ENTRY: key_err pulses, no other change.
- CONVERT:
  - Accumulator starts at 0.
  - On each of MAX_DIGITS cycles, from nibble MAX_DIGITS-1 down to nibble 0: acc = acc*10 + nibble. Unused high nibbles are 0, so the iteration count is fixed.
  - Then state -> PRESENT.
  - Latency: enter strobe at edge t means cmd_vld is first high in cycle t+1+MAX_DIGITS.
- PRESENT:
  - cmd_vld=1 and cmd_value is held stable until a cycle with cmd_vld&&cmd_rdy.
  - On that edge: disp_bcd clears, cnt clears, cmd_vld goes 0 next cycle, state -> IDLE.
- All key events in CONVERT or PRESENT are dropped silently: no key_err, no cmd_cancel. disp_bcd keeps showing the entry until the transfer.
- Timeout:
  - A cycle counter runs only in ENTRY and is cleared by any key_vld.
  - When it reaches TIMEOUT_CYC-1 with no key: clear the entry, pulse timeout_pulse, state -> IDLE.
  - If key_vld coincides with terminal count, the key wins and the counter restarts.
  - The counter is held at 0 in all other states.
- cmd_value remains at its last value after transfer; it is only meaningful while cmd_vld=1.
- Pulse outputs are never high for two consecutive cycles from a single event.

Decomposition:
- Shared package holds:
  - key code constants: KEY_ENTER=4'hA, KEY_BACK=4'hB, KEY_CANCEL=4'hC
  - state encoding (one-hot, 4 states)
  - a function computing the minimum VAL_W from MAX_DIGITS
- One sub-module: bcd_to_bin_seq. It is the iterative multiply-by-10 accumulator with start/done and parameters MAX_DIGITS and VAL_W.
- The controller owns the FSM, the digit shift register and the timeout counter.

Test Plan:
- Keys 1,2,3,A with cmd_rdy=1 -> cmd_vld high 5 cycles after the A strobe, cmd_value=123. disp_bcd=16'h0123 until transfer, then 0; disp_cnt=0.
- Keys 9,9,9,9,5 -> key_err pulse on the 5, disp_bcd=16'h9999. Then A -> cmd_value=9999.
- Keys 4,5,B,7,A -> disp_bcd=16'h0047, cmd_value=47. Separately, B on an empty entry -> key_err, disp_cnt stays 0.
- Keys 8,C -> cmd_cancel one cycle, disp_bcd=0, state IDLE. Then A -> key_err, cmd_vld stays 0. Also D in IDLE -> key_err only.
- Run with TIMEOUT_CYC=100:
  - key 3 then no keys -> timeout_pulse after 100 idle cycles, entry cleared.
  - Repeat with a key at idle cycle 99 -> no timeout, counter restarts.
- cmd_rdy=0: keys 6,A -> cmd_vld held with cmd_value=6; keys 1 and C are dropped with no pulses. Raise cmd_rdy -> single transfer. Repeat, then pull rst_n low in PRESENT -> cmd_vld 0 immediately and all outputs 0.
